// File: rtl/ddr3_burst_pkg.sv
// Shared types and pattern helpers for the DDR3 burst writer/reader test cores.
// The writer stores {24'h0, beat_index} in the low word of every beat.
package ddr3_burst_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GAP,
      S_REQ,
      S_DATA,
      S_STOP
   } state_t;

   localparam logic [7:0]  BURSTCNT_DEF = 8'h80;
   localparam logic [28:0] ADDRESS_DEF  = 29'h2400000;

   function automatic logic [31:0] expected_word(input logic [7:0] idx);
      return {24'h0, idx};
   endfunction

   function automatic logic [7:0] gap_cycles(input logic [2:0] sel);
      return (sel == 3'd0) ? 8'd0 : (8'd1 << sel);
   endfunction

endpackage

// File: rtl/ddr3_beat_check.sv
// Compares returned beats against the writer pattern; keeps the error
// counter and latches the first failing beat since reset.
module ddr3_beat_check
   import ddr3_burst_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        beat,
   input  logic        spurious,
   input  logic [7:0]  idx,
   input  logic [31:0] data,
   output logic        mismatch,
   output logic [15:0] err_cnt,
   output logic [7:0]  first_err_beat,
   output logic [31:0] first_err_data
);

   logic err;
   logic first_seen;

   assign mismatch = beat && (data != expected_word(idx));
   assign err      = mismatch || spurious;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_cnt        <= 16'h0;
         first_err_beat <= 8'h0;
         first_err_data <= 32'h0;
         first_seen     <= 1'b0;
      end else if (err) begin
         if (err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
         if (!first_seen) begin
            first_seen     <= 1'b1;
            first_err_beat <= spurious ? 8'hFF : idx;
            first_err_data <= data;
         end
      end
   end

endmodule

// File: rtl/ddr3_burst_reader.sv
// Read-side DDR3 test core: issues fixed read bursts at the pattern region,
// checks every returned beat and reports pass/error counts and timeouts.
module ddr3_burst_reader
   import ddr3_burst_pkg::*;
#(
   parameter logic [7:0]  BURSTCNT    = BURSTCNT_DEF,
   parameter logic [28:0] ADDRESS     = ADDRESS_DEF,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic        clk_ddr3,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        stop_req,
   input  logic [2:0]  wait_sel,
   input  logic        ddram_busy,
   output logic [7:0]  ddram_burstcnt,
   output logic [28:0] ddram_addr,
   output logic        ddram_rd,
   input  logic [63:0] ddram_dout,
   input  logic        ddram_dout_ready,
   output logic [15:0] burst_ok_cnt,
   output logic [15:0] err_cnt,
   output logic [7:0]  first_err_beat,
   output logic [31:0] first_err_data,
   output logic        timeout,
   output logic        stopped
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t        state;
   logic          stop_latch;
   logic          stop_now;
   logic          burst_bad;
   logic          mismatch;
   logic          beat;
   logic          spurious;
   logic          last_beat;
   logic [7:0]    gap_cnt;
   logic [7:0]    gap_tgt;
   logic [7:0]    beat_idx;
   logic [TW-1:0] to_cnt;
   logic          unused_hi;

   // upper half carries no pattern (writer byte enable is 8'h0F)
   assign unused_hi = ^ddram_dout[63:32];

   assign stop_now  = stop_latch || stop_req;
   assign beat      = ddram_dout_ready && (state == S_DATA);
   assign spurious  = ddram_dout_ready
                   && (state inside {S_GAP, S_REQ, S_STOP});
   assign last_beat = beat && (beat_idx == BURSTCNT - 8'd1);
   assign stopped   = (state == S_STOP);

   ddr3_beat_check u_check (
      .clk            (clk_ddr3),
      .reset_n        (reset_n),
      .beat           (beat),
      .spurious       (spurious),
      .idx            (beat_idx),
      .data           (ddram_dout[31:0]),
      .mismatch       (mismatch),
      .err_cnt        (err_cnt),
      .first_err_beat (first_err_beat),
      .first_err_data (first_err_data)
   );

   always_ff @(posedge clk_ddr3) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         stop_latch     <= 1'b0;
         burst_bad      <= 1'b0;
         gap_cnt        <= 8'h0;
         gap_tgt        <= 8'h0;
         beat_idx       <= 8'h0;
         to_cnt         <= '0;
         ddram_rd       <= 1'b0;
         ddram_burstcnt <= 8'h0;
         ddram_addr     <= 29'h0;
         burst_ok_cnt   <= 16'h0;
         timeout        <= 1'b0;
      end else begin
         if (stop_req)
            stop_latch <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (stop_now) begin
                  state <= S_STOP;
               end else if (enable) begin
                  state   <= S_GAP;
                  gap_cnt <= 8'h0;
                  gap_tgt <= gap_cycles(wait_sel);
               end
            end
            S_GAP: begin
               if (stop_now) begin
                  state <= S_STOP;
               end else if (!enable) begin
                  state <= S_IDLE;
               end else if (gap_cnt == gap_tgt) begin
                  state          <= S_REQ;
                  ddram_rd       <= 1'b1;
                  ddram_burstcnt <= BURSTCNT;
                  ddram_addr     <= ADDRESS;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            S_REQ: begin
               if (!ddram_busy) begin
                  state          <= S_DATA;
                  ddram_rd       <= 1'b0;
                  ddram_burstcnt <= 8'h0;
                  ddram_addr     <= 29'h0;
                  beat_idx       <= 8'h0;
                  to_cnt         <= '0;
                  burst_bad      <= 1'b0;
               end
            end
            S_DATA: begin
               if (beat) begin
                  to_cnt   <= '0;
                  beat_idx <= beat_idx + 8'd1;
                  if (mismatch)
                     burst_bad <= 1'b1;
                  if (last_beat) begin
                     if (!burst_bad && !mismatch
                         && burst_ok_cnt != 16'hFFFF)
                        burst_ok_cnt <= burst_ok_cnt + 16'd1;
                     if (stop_now) begin
                        state <= S_STOP;
                     end else if (enable) begin
                        state   <= S_GAP;
                        gap_cnt <= 8'h0;
                        gap_tgt <= gap_cycles(wait_sel);
                     end else begin
                        state <= S_IDLE;
                     end
                  end
               end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                  timeout <= 1'b1;
                  state   <= S_STOP;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_STOP: begin
               state <= S_STOP;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_burst_reader.sv
// Scoreboard bench for ddr3_burst_reader: a memory BFM answers read bursts,
// a transaction-level model predicts counters, a monitor checks requests.
module tb_ddr3_burst_reader;

   localparam int TMO = 4096;

   logic        clk_ddr3 = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic        stop_req = 1'b0;
   logic [2:0]  wait_sel = 3'd0;
   logic        ddram_busy = 1'b0;
   logic [7:0]  ddram_burstcnt;
   logic [28:0] ddram_addr;
   logic        ddram_rd;
   logic [63:0] ddram_dout = 64'h0;
   logic        ddram_dout_ready = 1'b0;
   logic [15:0] burst_ok_cnt;
   logic [15:0] err_cnt;
   logic [7:0]  first_err_beat;
   logic [31:0] first_err_data;
   logic        timeout;
   logic        stopped;

   ddr3_burst_reader dut (
      .clk_ddr3         (clk_ddr3),
      .reset_n          (reset_n),
      .enable           (enable),
      .stop_req         (stop_req),
      .wait_sel         (wait_sel),
      .ddram_busy       (ddram_busy),
      .ddram_burstcnt   (ddram_burstcnt),
      .ddram_addr       (ddram_addr),
      .ddram_rd         (ddram_rd),
      .ddram_dout       (ddram_dout),
      .ddram_dout_ready (ddram_dout_ready),
      .burst_ok_cnt     (burst_ok_cnt),
      .err_cnt          (err_cnt),
      .first_err_beat   (first_err_beat),
      .first_err_data   (first_err_data),
      .timeout          (timeout),
      .stopped          (stopped)
   );

   always #5 clk_ddr3 = ~clk_ddr3;

   int errors = 0;
   int checks = 0;
   int unsigned cyc = 0;

   initial forever begin
      @(posedge clk_ddr3);
      cyc = cyc + 1;
   end

   // reference model: what the counters must read, derived from the beats sent
   int          m_ok = 0;
   int          m_err = 0;
   bit          m_fs = 0;
   logic [7:0]  m_fb = 8'h0;
   logic [31:0] m_fd = 32'h0;
   bit          m_bad = 0;
   bit          freeze = 0;

   function automatic void model_err(logic [7:0] b, logic [31:0] d);
      if (m_err < 65535) m_err++;
      if (!m_fs) begin
         m_fs = 1;
         m_fb = b;
         m_fd = d;
      end
   endfunction

   function automatic void model_beat(logic [31:0] d, int i);
      if (i == 0) m_bad = 0;
      if (d != 32'(i)) begin
         m_bad = 1;
         model_err(8'(i), d);
      end
      if (i == 127 && !m_bad && m_ok < 65535) m_ok++;
   endfunction

   function automatic void model_reset();
      m_ok = 0;
      m_err = 0;
      m_fs = 0;
      m_fb = 8'h0;
      m_fd = 32'h0;
      m_bad = 0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // expected requests, popped by the monitor on each acceptance
   logic [36:0] req_q[$];
   logic [36:0] req_exp = {8'h80, 29'h2400000};

   // memory BFM
   int          beats_left = 0;
   int          bidx = 0;
   int          plan_beats = 128;
   int          err_beat = 999;
   logic [31:0] err_data = 32'h0;
   int          acc_count = 0;
   int unsigned t9 = 0;
   bit          hold_busy = 0;
   bit          rand_busy = 0;
   bit          rand_err = 0;
   bit          stray_req = 0;

   initial forever begin
      @(negedge clk_ddr3);
      if (ddram_rd && !ddram_busy && reset_n) begin
         acc_count++;
         beats_left = plan_beats;
         bidx = 0;
         if (rand_err) begin
            err_beat = $urandom_range(0, 255);
            err_data = $urandom;
         end
      end
      @(posedge clk_ddr3);
      #1;
      ddram_busy = hold_busy || (rand_busy && $urandom_range(0, 3) == 0);
      ddram_dout_ready = 1'b0;
      if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
         ddram_dout[63:32] = $urandom;
         ddram_dout[31:0] = (bidx == err_beat) ? err_data : 32'(bidx);
         ddram_dout_ready = 1'b1;
         if (!freeze) model_beat(ddram_dout[31:0], bidx);
         if (bidx == 9) t9 = cyc + 1;
         bidx++;
         beats_left--;
      end else if (stray_req && beats_left == 0) begin
         stray_req = 0;
         ddram_dout = {$urandom, $urandom};
         ddram_dout_ready = 1'b1;
         model_err(8'hFF, ddram_dout[31:0]);
      end
   end

   // request monitor
   logic        prev_rd = 1'b0;
   logic [36:0] prev_req = '0;
   logic [36:0] got;
   int          stall_cyc = 0;

   initial forever begin
      @(negedge clk_ddr3);
      got = {ddram_burstcnt, ddram_addr};
      if (ddram_rd && ddram_busy) begin
         stall_cyc++;
         if (prev_rd) begin
            checks++;
            if (got !== prev_req) begin
               errors++;
               $display("FAIL req_stable actual=%0h required=%0h",
                        got, prev_req);
            end
         end
      end
      if (ddram_rd && !ddram_busy && reset_n) begin
         checks++;
         if (req_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req actual=%0h required=none", got);
         end else if (got !== req_q[0]) begin
            errors++;
            $display("FAIL req_fields actual=%0h required=%0h",
                     got, req_q[0]);
            void'(req_q.pop_front());
         end else begin
            void'(req_q.pop_front());
         end
      end
      prev_rd = ddram_rd;
      prev_req = got;
   end

   task automatic check_zero(string tag);
      chk({tag, "_rd"}, 64'(ddram_rd), 0);
      chk({tag, "_burstcnt"}, 64'(ddram_burstcnt), 0);
      chk({tag, "_addr"}, 64'(ddram_addr), 0);
      chk({tag, "_ok"}, 64'(burst_ok_cnt), 0);
      chk({tag, "_err"}, 64'(err_cnt), 0);
      chk({tag, "_fbeat"}, 64'(first_err_beat), 0);
      chk({tag, "_fdata"}, 64'(first_err_data), 0);
      chk({tag, "_timeout"}, 64'(timeout), 0);
      chk({tag, "_stopped"}, 64'(stopped), 0);
   endtask

   task automatic do_reset(string tag);
      reset_n = 1'b0;
      enable = 1'b0;
      stop_req = 1'b0;
      req_q.delete();
      model_reset();
      repeat (2) @(negedge clk_ddr3);
      check_zero(tag);
      reset_n = 1'b1;
   endtask

   task automatic wait_acc(int n);
      int k = 0;
      while (acc_count < n && k < 3000) begin
         @(negedge clk_ddr3);
         k++;
      end
      chk("request_issued", 64'(acc_count >= n), 1);
   endtask

   task automatic wait_rd();
      int k = 0;
      while (!ddram_rd && k < 1000) begin
         @(negedge clk_ddr3);
         k++;
      end
      chk("rd_seen", 64'(ddram_rd), 1);
   endtask

   task automatic wait_done();
      int k = 0;
      while ((beats_left > 0 || ddram_rd) && k < 3000) begin
         @(negedge clk_ddr3);
         k++;
      end
      chk("burst_drained", 64'(beats_left), 0);
      repeat (4) @(negedge clk_ddr3);
   endtask

   task automatic check_model(string tag);
      chk({tag, "_ok"}, 64'(burst_ok_cnt), 64'(m_ok));
      chk({tag, "_err"}, 64'(err_cnt), 64'(m_err));
      chk({tag, "_fbeat"}, 64'(first_err_beat), 64'(m_fb));
      chk({tag, "_fdata"}, 64'(first_err_data), 64'(m_fd));
   endtask

   initial begin
      #(10_000_000);
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int ok0;
      int unsigned tcyc;
      int k;

      do_reset("reset");

      // normal run: three back-to-back bursts
      a0 = acc_count;
      repeat (3) req_q.push_back(req_exp);
      wait_sel = 3'd0;
      enable = 1'b1;
      wait_acc(a0 + 3);
      enable = 1'b0;
      wait_done();
      check_model("normal");
      chk("normal_ok3", 64'(burst_ok_cnt), 3);

      // busy stall for five cycles in REQ
      a0 = acc_count;
      stall_cyc = 0;
      hold_busy = 1;
      req_q.push_back(req_exp);
      enable = 1'b1;
      wait_rd();
      repeat (4) @(negedge clk_ddr3);
      hold_busy = 0;
      enable = 1'b0;
      wait_acc(a0 + 1);
      wait_done();
      chk("stall_cycles", 64'(stall_cyc), 5);
      chk("stall_one_req", 64'(acc_count - a0), 1);
      check_model("stall");

      // data error on beat 17
      ok0 = m_ok;
      a0 = acc_count;
      err_beat = 17;
      err_data = 32'h000000AA;
      wait_sel = 3'($urandom_range(0, 3));
      req_q.push_back(req_exp);
      enable = 1'b1;
      wait_acc(a0 + 1);
      enable = 1'b0;
      wait_done();
      err_beat = 999;
      chk("derr_cnt", 64'(err_cnt), 1);
      chk("derr_beat", 64'(first_err_beat), 17);
      chk("derr_data", 64'(first_err_data), 64'h000000AA);
      chk("derr_ok_same", 64'(burst_ok_cnt), 64'(ok0));

      // randomized bursts: random busy, gaps and corrupted beats
      a0 = acc_count;
      rand_busy = 1;
      rand_err = 1;
      wait_sel = 3'($urandom_range(0, 3));
      repeat (3) req_q.push_back(req_exp);
      enable = 1'b1;
      wait_acc(a0 + 3);
      enable = 1'b0;
      wait_done();
      rand_busy = 0;
      rand_err = 0;
      err_beat = 999;
      check_model("random");

      // stop request while the read is pending
      a0 = acc_count;
      hold_busy = 1;
      req_q.push_back(req_exp);
      enable = 1'b1;
      wait_rd();
      stop_req = 1'b1;
      @(negedge clk_ddr3);
      stop_req = 1'b0;
      hold_busy = 0;
      wait_acc(a0 + 1);
      wait_done();
      repeat (300) @(negedge clk_ddr3);
      chk("stop_stopped", 64'(stopped), 1);
      chk("stop_one_req", 64'(acc_count - a0), 1);
      check_model("stop");

      // timeout after ten beats
      do_reset("reset2");
      a0 = acc_count;
      plan_beats = 10;
      req_q.push_back(req_exp);
      enable = 1'b1;
      wait_acc(a0 + 1);
      k = 0;
      while (!timeout && k < TMO + 2000) begin
         @(negedge clk_ddr3);
         k++;
      end
      tcyc = cyc;
      plan_beats = 128;
      chk("tmo_flag", 64'(timeout), 1);
      chk("tmo_stopped", 64'(stopped), 1);
      chk("tmo_latency", 64'(tcyc - t9), 64'(TMO));
      check_model("tmo");

      // reset in mid-burst, remaining beats arrive in IDLE
      do_reset("reset3");
      a0 = acc_count;
      req_q.push_back(req_exp);
      enable = 1'b1;
      wait_acc(a0 + 1);
      k = 0;
      while (bidx < 50 && k < 2000) begin
         @(negedge clk_ddr3);
         k++;
      end
      freeze = 1;
      do_reset("midreset");
      wait_done();
      chk("stray_beats", 64'(bidx), 128);
      check_zero("after_stray");
      freeze = 0;

      // stray beat while waiting in GAP
      a0 = acc_count;
      wait_sel = 3'd7;
      req_q.push_back(req_exp);
      enable = 1'b1;
      repeat (10) @(negedge clk_ddr3);
      stray_req = 1;
      wait_acc(a0 + 1);
      enable = 1'b0;
      wait_done();
      chk("spur_err", 64'(err_cnt), 1);
      chk("spur_beat", 64'(first_err_beat), 64'hFF);
      check_model("spur");

      chk("req_queue_empty", 64'(req_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
